// File: rtl/icache_if.sv
// Bus bundle between the instruction cache controller, the IF stage and the
// 128-bit-line instruction memory.
//
// Handshake: the cache raises BUSYWAIT whenever the current PC is not served
// this cycle, and the pipeline holds PC steady until BUSYWAIT drops.
// Toward memory, MEM_READ stays high, with a constant MEM_ADDRESS, until a
// posedge samples MEM_BUSYWAIT low. MEM_READDATA must be valid from that edge
// through the following cycle.
interface icache_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          PC;
  logic [31:0]          INSTRUCTION;
  logic                 BUSYWAIT;
  logic                 FLUSH;
  logic                 MEM_READ;
  logic [27:0]          MEM_ADDRESS;
  logic [127:0]         MEM_READDATA;
  logic                 MEM_BUSYWAIT;
  logic [CNT_WIDTH-1:0] HIT_COUNT;
  logic [CNT_WIDTH-1:0] MISS_COUNT;
  logic [1:0]           dbg_state;

  // Environment side: the pipeline and the instruction memory.
  modport master (
    output PC, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS,
           HIT_COUNT, MISS_COUNT, dbg_state
  );

  // Cache controller side.
  modport slave (
    input  PC, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS,
           HIT_COUNT, MISS_COUNT, dbg_state
  );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller. It performs a combinational
// tag lookup, fills a line from instruction memory on a miss, supports a
// deferred invalidate-all, and keeps saturating hit/miss counters.
module icache_controller #(
  parameter int NUM_SETS  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic     CLOCK,
  input  logic     RESET,
  icache_if.slave  bus
);
  localparam int          INDEX_BITS = $clog2(NUM_SETS);
  localparam int          TAG_BITS   = 28 - INDEX_BITS;
  localparam logic [31:0] NOP        = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d;
  logic                  flush_q, flush_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
  logic [TAG_BITS-1:0]   tag_q  [NUM_SETS];
  logic [127:0]          data_q [NUM_SETS];

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [1:0]            pc_word;
  logic                  hit;
  logic                  stall;
  logic                  mem_read;
  logic                  fill_en;
  logic [31:0]           line_word;
  logic                  unused_pc_bits;

  assign pc_word        = bus.PC[3:2];
  assign pc_index       = bus.PC[3+INDEX_BITS:4];
  assign pc_tag         = bus.PC[31:4+INDEX_BITS];
  assign unused_pc_bits = ^bus.PC[1:0];

  // A pending flush masks every line so no stale word escapes before the clear.
  assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag) && !flush_q;
  assign line_word = data_q[pc_index][{pc_word, 5'b00000} +: 32];

  // Next-state, counter, valid-bit and flush-flag logic.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    flush_d    = flush_q | bus.FLUSH;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stall      = 1'b1;
    mem_read   = 1'b0;
    fill_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The flag is consumed here; a FLUSH arriving on this same edge re-arms it.
        flush_d = bus.FLUSH;
        if (flush_q) begin
          valid_d = '0;
        end
        if (hit) begin
          stall = 1'b0;
          if (hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end else begin
          state_d = S_MEM_READ;
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        fill_en           = 1'b1;
        valid_d[pc_index] = 1'b1;
        state_d           = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state with asynchronous clear; tags and data keep their contents.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      flush_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Line fill: capture the returned block and the tag of the held PC.
  always_ff @(posedge CLOCK) begin
    if (fill_en) begin
      data_q[pc_index] <= bus.MEM_READDATA;
      tag_q[pc_index]  <= pc_tag;
    end
  end

  assign bus.BUSYWAIT    = stall | ~RESET;
  assign bus.INSTRUCTION = (stall | ~RESET) ? NOP : line_word;
  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = bus.PC[31:4];
  assign bus.HIT_COUNT   = hit_cnt_q;
  assign bus.MISS_COUNT  = miss_cnt_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: two instances (16-bit and 4-bit counters)
// share one stimulus and one memory responder. A per-cycle miss-penalty
// timeline model predicts every output; directed steps pin literal values.
module tb_icache_controller;
  localparam logic [31:0] NOP = 32'h00000013;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pc;
  logic         flush;
  int           mem_lat;
  int           mem_cnt = 0;
  logic         mem_busy;
  logic [127:0] rd_line = '0;

  int total = 0;
  int bad   = 0;

  icache_if #(.CNT_WIDTH(16)) bus0 ();
  icache_if #(.CNT_WIDTH(4))  bus1 ();

  icache_controller #(.NUM_SETS(8), .CNT_WIDTH(16)) u_dut0 (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus0.slave)
  );

  icache_controller #(.NUM_SETS(8), .CNT_WIDTH(4)) u_dut1 (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus1.slave)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Backing store contents: block 0 is fixed, others encode their address.
  function automatic logic [127:0] line_of(input logic [27:0] blk);
    logic [127:0] l;
    if (blk == 28'd0) begin
      l = {32'h0000F613, 32'h11111111, 32'h22222222, 32'h8F108093};
    end else begin
      for (int w = 0; w < 4; w++) begin
        l[32*w +: 32] = 32'hC0000000 + ({4'h0, blk} << 4) + w;
      end
    end
    return l;
  endfunction

  // Memory responder: busy for the first mem_lat-1 cycles of a request,
  // then ready with the line, which stays on the bus until the next request.
  assign mem_busy = bus0.MEM_READ && (mem_cnt < mem_lat - 1);

  always @(posedge clk) begin
    if (!rst_n || !bus0.MEM_READ) mem_cnt <= 0;
    else                          mem_cnt <= mem_cnt + 1;
    if (bus0.MEM_READ && !mem_busy) rd_line <= line_of(bus0.MEM_ADDRESS);
  end

  assign bus0.PC           = pc;
  assign bus1.PC           = pc;
  assign bus0.FLUSH        = flush;
  assign bus1.FLUSH        = flush;
  assign bus0.MEM_READDATA = rd_line;
  assign bus1.MEM_READDATA = rd_line;
  assign bus0.MEM_BUSYWAIT = mem_busy;
  assign bus1.MEM_BUSYWAIT = mem_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until BUSYWAIT drops; reports stall cycles and MEM_READ cycles.
  task automatic wait_ready(output int n, output int mr);
    n  = 0;
    mr = 0;
    while (bus0.BUSYWAIT && n < 100) begin
      n++;
      if (bus0.MEM_READ) mr++;
      tick();
    end
    check("ready_timeout", {31'd0, bus0.BUSYWAIT}, 32'd0);
  endtask

  // Reference model: a miss costs one lookup cycle, mem_lat read cycles and
  // one fill cycle. A flush is remembered and wipes the cache at the next lookup.
  bit          m_valid [8];
  bit [27:0]   m_blk   [8];
  bit [127:0]  m_line  [8];
  bit          m_flush = 0;
  int          m_phase = 0;
  int          m_hits  = 0;
  int          m_miss  = 0;

  function automatic logic [31:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [31:0] e_instr;
    logic        e_busy;
    logic        e_mr;
    bit          m_hit;
    int          idx;
    int          off;
    logic [27:0] blk;
    idx   = int'(pc[6:4]);
    off   = int'(pc[3:2]);
    blk   = pc[31:4];
    m_hit = 1'b0;
    if (!rst_n) begin
      e_busy  = 1'b1;
      e_mr    = 1'b0;
      e_instr = NOP;
      m_hits  = 0;
      m_miss  = 0;
      m_phase = 0;
      m_flush = 0;
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
    end else if (m_phase == 0) begin
      m_hit   = m_valid[idx] && (m_blk[idx] == blk) && !m_flush;
      e_busy  = !m_hit;
      e_mr    = 1'b0;
      e_instr = m_hit ? m_line[idx][off*32 +: 32] : NOP;
    end else begin
      e_busy  = 1'b1;
      e_mr    = (m_phase <= mem_lat);
      e_instr = NOP;
    end

    check("busywait",    {31'd0, bus0.BUSYWAIT}, {31'd0, e_busy});
    check("instruction", bus0.INSTRUCTION, e_instr);
    check("mem_read",    {31'd0, bus0.MEM_READ}, {31'd0, e_mr});
    check("mem_address", {4'd0, bus0.MEM_ADDRESS}, {4'd0, blk});
    check("hit_count",   {16'd0, bus0.HIT_COUNT}, sat(m_hits, 16));
    check("miss_count",  {16'd0, bus0.MISS_COUNT}, sat(m_miss, 16));
    check("busywait_w4", {31'd0, bus1.BUSYWAIT}, {31'd0, e_busy});
    check("instr_w4",    bus1.INSTRUCTION, e_instr);
    check("mem_read_w4", {31'd0, bus1.MEM_READ}, {31'd0, e_mr});
    check("hit_count_w4",  {28'd0, bus1.HIT_COUNT}, sat(m_hits, 4));
    check("miss_count_w4", {28'd0, bus1.MISS_COUNT}, sat(m_miss, 4));

    // Advance the model to what the next posedge produces.
    if (rst_n) begin
      if (m_phase == 0) begin
        if (m_flush) for (int i = 0; i < 8; i++) m_valid[i] = 0;
        m_flush = flush;
        if (m_hit) begin
          m_hits++;
        end else begin
          m_miss++;
          m_phase = 1;
        end
      end else if (m_phase <= mem_lat) begin
        m_flush = m_flush | flush;
        m_phase++;
      end else begin
        m_flush      = m_flush | flush;
        m_valid[idx] = 1;
        m_blk[idx]   = blk;
        m_line[idx]  = line_of(blk);
        m_phase      = 0;
      end
    end
  end

  // Directed scenario driver.
  initial begin
    int n;
    int mr;
    rst_n   = 1'b0;
    pc      = 32'h0;
    flush   = 1'b0;
    mem_lat = 3;
    repeat (3) tick();
    check("rst_busywait",  {31'd0, bus0.BUSYWAIT}, 32'd1);
    check("rst_mem_read",  {31'd0, bus0.MEM_READ}, 32'd0);
    check("rst_instr",     bus0.INSTRUCTION, NOP);
    check("rst_hit_count", {16'd0, bus0.HIT_COUNT}, 32'd0);
    check("rst_miss_count", {16'd0, bus0.MISS_COUNT}, 32'd0);
    check("rst_state",     {30'd0, bus0.dbg_state}, 32'd0);

    // Cold miss on PC 0 with a 3-cycle memory.
    rst_n = 1'b1;
    wait_ready(n, mr);
    check("cold_stall_cycles", n, 32'd5);
    check("cold_read_cycles",  mr, 32'd3);
    check("cold_instr",        bus0.INSTRUCTION, 32'h8F108093);
    check("cold_miss_count",   {16'd0, bus0.MISS_COUNT}, 32'd1);

    // Same-line hit on word 3.
    pc = 32'h0000000C;
    #1;
    check("hit_instr",    bus0.INSTRUCTION, 32'h0000F613);
    check("hit_busywait", {31'd0, bus0.BUSYWAIT}, 32'd0);
    repeat (4) tick();
    check("hit_count_4",  {16'd0, bus0.HIT_COUNT}, 32'd4);

    // Conflict on index 0, then back to the evicted line.
    pc = 32'h00000080;
    #1;
    check("conflict_busywait", {31'd0, bus0.BUSYWAIT}, 32'd1);
    check("conflict_address",  {4'd0, bus0.MEM_ADDRESS}, 32'h00000008);
    wait_ready(n, mr);
    check("conflict_stall_cycles", n, 32'd5);
    check("conflict_instr", bus0.INSTRUCTION, 32'hC0000080);
    pc = 32'h00000000;
    #1;
    check("evicted_busywait", {31'd0, bus0.BUSYWAIT}, 32'd1);
    wait_ready(n, mr);
    check("evicted_miss_count", {16'd0, bus0.MISS_COUNT}, 32'd3);
    check("evicted_instr", bus0.INSTRUCTION, 32'h8F108093);

    // Reset in the middle of a memory read.
    pc = 32'h00000040;
    tick();
    check("midfill_mem_read", {31'd0, bus0.MEM_READ}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_read", {31'd0, bus0.MEM_READ}, 32'd0);
    check("async_state",    {30'd0, bus0.dbg_state}, 32'd0);
    check("async_busywait", {31'd0, bus0.BUSYWAIT}, 32'd1);
    pc = 32'h00000000;
    tick();
    rst_n = 1'b1;
    wait_ready(n, mr);
    check("refill_stall_cycles", n, 32'd5);
    check("refill_miss_count", {16'd0, bus0.MISS_COUNT}, 32'd1);
    check("refill_instr", bus0.INSTRUCTION, 32'h8F108093);

    // Flush pulse while line 2 is being filled with a 4-cycle memory.
    mem_lat = 4;
    pc      = 32'h00000020;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_ready(n, mr);
    check("flush_fill_stall_cycles", n, 32'd9);
    check("flush_fill_read_cycles",  mr, 32'd6);
    check("flush_fill_miss_count", {16'd0, bus0.MISS_COUNT}, 32'd3);
    check("flush_fill_instr", bus0.INSTRUCTION, 32'hC0000020);

    // Flush while idle on a hit: the next lookup is forced to miss.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle_busywait", {31'd0, bus0.BUSYWAIT}, 32'd1);
    wait_ready(n, mr);
    check("flush_idle_stall_cycles", n, 32'd6);
    check("flush_idle_miss_count", {16'd0, bus0.MISS_COUNT}, 32'd4);

    // Twenty hits saturate the 4-bit counter.
    pc = 32'h00000024;
    repeat (20) tick();
    check("sat_hit_count_w4", {28'd0, bus1.HIT_COUNT}, 32'h0000000F);
    check("sat_hit_count",    {16'd0, bus0.HIT_COUNT}, 32'd21);
    check("sat_instr",        bus1.INSTRUCTION, 32'hC0000021);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
